paj7620_i2c_slave: RTL

- I2C target (responder) that models the PAJ7620 gesture sensor, as seen from the bus side.
- It sits opposite the i2c_ctrl master. It is used as the sensor model in board-less simulation and as a loop-back target on the FPGA.
- It decodes START/STOP, matches the 7-bit address, accepts register writes and returns register reads, including the clear-on-read gesture flags.
- A gesture source drives it and it raises an active-low interrupt.

---
 rtl/paj7620_i2c_slave.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/paj7620_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : paj7620_i2c_slave
// Description : I2C target modelling the PAJ7620 gesture sensor bus view.
//               START/STOP decode, 7-bit address match, register writes,
//               register reads with clear-on-read gesture flags, int_n.
//               Optional clock stretching after every ACK/NACK bit is built
//               when the macro CLK_STRETCH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module paj7620_i2c_slave #(
  parameter logic [6:0]  SLV_ADDR    = 7'h73,
  parameter logic [15:0] PART_ID     = 16'h7620,
  parameter logic [7:0]  STRETCH_CYC = 8'd50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic       gest_valid,
  input  logic [8:0] gest_code,
  output logic       int_n,
  output logic       bank,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    REG      = 4'd3,
    REG_ACK  = 4'd4,
    WDATA    = 4'd5,
    WACK     = 4'd6,
    RDATA    = 4'd7,
    RACK     = 4'd8
  } state_t;

  state_t     state_q;
  logic       scl_s1_q, scl_s2_q, scl_d_q;
  logic       sda_s1_q, sda_s2_q, sda_d_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q;
  logic [6:0] tx_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       mack_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       bank_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [8:0] flags_q;
  logic [8:0] flags_d;
  logic       int_n_q;
  logic [8:0] w_clr;
  logic [7:0] w_rd_byte;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;

  // Two-stage synchronizers plus one edge register per bus line; idle-high reset avoids false edges
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_d_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_d_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_in; scl_s2_q <= scl_s1_q; scl_d_q <= scl_s2_q;
      sda_s1_q <= sda_in; sda_s2_q <= sda_s1_q; sda_d_q <= sda_s2_q;
    end
  end

  assign w_scl_rise = scl_s2_q & ~scl_d_q;
  assign w_scl_fall = ~scl_s2_q & scl_d_q;
  assign w_start    = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign w_stop     = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;

  // Read data selected by bank and pointer
  always_comb begin
    w_rd_byte = 8'h00;
    if (ptr_q == 8'hEF) begin
      w_rd_byte = {7'b0, bank_q};
    end else if (!bank_q) begin
      case (ptr_q)
        8'h00:   w_rd_byte = PART_ID[7:0];
        8'h01:   w_rd_byte = PART_ID[15:8];
        8'h43:   w_rd_byte = flags_q[7:0];
        8'h44:   w_rd_byte = {7'b0, flags_q[8]};
        default: w_rd_byte = 8'h00;
      endcase
    end
  end

  // Flag clear at the master ACK/NACK sample of a flag register; new gestures override the clear
  always_comb begin
    w_clr = 9'h000;
    if (state_q == RACK && w_scl_rise && !bank_q) begin
      if (ptr_q == 8'h43)      w_clr = 9'h0FF;
      else if (ptr_q == 8'h44) w_clr = 9'h100;
    end
    flags_d = (flags_q & ~w_clr) | (gest_valid ? gest_code : 9'h000);
  end

  // Gesture flag register and registered interrupt
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      flags_q <= 9'h000;
      int_n_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      int_n_q <= ~|flags_q;
    end
  end

  // Protocol FSM: sample on SCL rise, change SDA drive only after SCL fall
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 7'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      bank_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (w_stop) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (w_start) begin
        state_q  <= ADDR;
        cnt_q    <= 4'd0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR, REG, WDATA: begin
            if (w_scl_rise && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_s2_q};
              cnt_q   <= cnt_q + 4'd1;
            end else if (w_scl_fall && cnt_q == 4'd8) begin
              cnt_q <= 4'd0;
              if (state_q == ADDR) begin
                if (shift_q[7:1] == SLV_ADDR) begin
                  state_q  <= ADDR_ACK;
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  rw_q     <= shift_q[0];
                end else begin
                  state_q <= IDLE;
                end
              end else if (state_q == REG) begin
                ptr_q    <= shift_q;
                state_q  <= REG_ACK;
                sda_oe_q <= 1'b1;
              end else begin
                state_q  <= WACK;
                sda_oe_q <= 1'b1;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                state_q  <= RDATA;
                tx_q     <= w_rd_byte[6:0];
                sda_oe_q <= ~w_rd_byte[7];
              end else begin
                state_q  <= REG;
                sda_oe_q <= 1'b0;
              end
            end
          end
          REG_ACK: begin
            if (w_scl_fall) begin
              state_q  <= WDATA;
              cnt_q    <= 4'd0;
              sda_oe_q <= 1'b0;
            end
          end
          WACK: begin
            if (w_scl_rise) begin
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_data_q   <= shift_q;
              if (ptr_q == 8'hEF) bank_q <= shift_q[0];
              ptr_q <= ptr_q + 8'd1;
            end else if (w_scl_fall) begin
              state_q  <= WDATA;
              cnt_q    <= 4'd0;
              sda_oe_q <= 1'b0;
            end
          end
          RDATA: begin
            if (w_scl_rise && cnt_q != 4'd8) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (w_scl_fall) begin
              if (cnt_q == 4'd8) begin
                state_q  <= RACK;
                sda_oe_q <= 1'b0;
              end else begin
                sda_oe_q <= ~tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
              end
            end
          end
          RACK: begin
            if (w_scl_rise) begin
              mack_q <= sda_s2_q;
              if (!sda_s2_q) ptr_q <= ptr_q + 8'd1;
            end else if (w_scl_fall) begin
              cnt_q <= 4'd0;
              if (!mack_q) begin
                state_q  <= RDATA;
                tx_q     <= w_rd_byte[6:0];
                sda_oe_q <= ~w_rd_byte[7];
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CLK_STRETCH_EN
  logic [7:0] stretch_cnt_q;
  logic       scl_oe_q;
  logic       w_ack_end;

  assign w_ack_end = w_scl_fall && (state_q == ADDR_ACK || state_q == REG_ACK ||
                                    state_q == WACK     || state_q == RACK);

  // Hold SCL low for STRETCH_CYC cycles after each ACK/NACK bit; START/STOP release at once
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scl_oe_q      <= 1'b0;
      stretch_cnt_q <= 8'd0;
    end else if (w_start || w_stop) begin
      scl_oe_q      <= 1'b0;
      stretch_cnt_q <= 8'd0;
    end else if (w_ack_end) begin
      scl_oe_q      <= 1'b1;
      stretch_cnt_q <= STRETCH_CYC - 8'd1;
    end else if (scl_oe_q) begin
      if (stretch_cnt_q == 8'd0) scl_oe_q <= 1'b0;
      else stretch_cnt_q <= stretch_cnt_q - 8'd1;
    end
  end

  assign scl_oe = scl_oe_q;
`else
  logic unused_stretch;
  assign unused_stretch = ^STRETCH_CYC;
  assign scl_oe = 1'b0;
`endif

  assign sda_oe    = sda_oe_q;
  assign int_n     = int_n_q;
  assign bank      = bank_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
